// File: rtl/boom_iomshr_pkg.sv
// boom_iomshr_pkg: shared constants and types for the IO MSHR scheduler.
// Holds mem_cmd encodings, slot state type and width helper.
package boom_iomshr_pkg;

    localparam logic [4:0] M_XRD       = 5'h0;
    localparam logic [4:0] M_XWR       = 5'h1;
    localparam logic [4:0] M_PFR       = 5'h2;
    localparam logic [4:0] M_PFW       = 5'h3;
    localparam logic [4:0] M_XA_SWAP   = 5'h4;
    localparam logic [4:0] M_FLUSH_ALL = 5'h5;
    localparam logic [4:0] M_XLR       = 5'h6;
    localparam logic [4:0] M_XSC       = 5'h7;

    localparam int N_SLOTS_MAX = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } slot_state_e;

    // Index width that stays legal for a single-entry pool.
    function automatic int src_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/boom_iomshr_order_fifo.sv
// boom_iomshr_order_fifo: slot-index FIFO recording allocation order.
// Ports: clock, reset (async, active-low), push/push_idx, pop, head, empty, full.
module boom_iomshr_order_fifo
    import boom_iomshr_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_idx,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full
);

    localparam int PW = src_w(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_q;
    logic [PW-1:0] wr_q;
    logic [CW-1:0] cnt_q;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_q] <= push_idx;
                wr_q        <= ptr_inc(wr_q);
            end
            if (pop) begin
                rd_q <= ptr_inc(rd_q);
            end
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign head  = mem_q[rd_q];
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(DEPTH));

endmodule

// File: rtl/boom_iomshr_sched.sv
// boom_iomshr_sched: allocates IO requests to IO MSHR slots, NACKs SC,
// orders A-channel grants by allocation, routes D beats, drains on fence.
// Ports: req_* in / req_ready, nack_*; slot_* alloc/broadcast/done;
// slot_a_* and a_* (merged A); d_* and slot_d_* (D routing);
// fence_req / fence_done. reset is async, active-low.
// Optional: IOMSHR_SCHED_ASSERT_EN adds concurrent checks.
module boom_iomshr_sched
    import boom_iomshr_pkg::*;
#(
    parameter int N_SLOTS = 2,
    parameter int ADDR_W  = 40,
    parameter int DATA_W  = 64,
    parameter int TAG_W   = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [4:0]                  req_cmd,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic [DATA_W-1:0]           req_data,
    input  logic [TAG_W-1:0]            req_tag,
    output logic                        nack_valid,
    output logic [TAG_W-1:0]            nack_tag,
    output logic [N_SLOTS-1:0]          slot_alloc,
    output logic [ADDR_W-1:0]           slot_addr,
    output logic [DATA_W-1:0]           slot_data,
    output logic [TAG_W-1:0]            slot_tag,
    output logic [4:0]                  slot_cmd,
    input  logic [N_SLOTS-1:0]          slot_done,
    input  logic [N_SLOTS-1:0]          slot_a_valid,
    output logic [N_SLOTS-1:0]          slot_a_ready,
    output logic                        a_valid,
    input  logic                        a_ready,
    output logic [src_w(N_SLOTS)-1:0]   a_source,
    input  logic                        d_valid,
    input  logic [src_w(N_SLOTS)-1:0]   d_source,
    output logic                        d_ready,
    output logic [N_SLOTS-1:0]          slot_d_valid,
    input  logic [N_SLOTS-1:0]          slot_d_ready,
    input  logic                        fence_req,
    output logic                        fence_done
);

    localparam int SW = src_w(N_SLOTS);

    slot_state_e          state_q [N_SLOTS];
    slot_state_e          state_d [N_SLOTS];
    logic [N_SLOTS-1:0]   idle;
    logic [N_SLOTS-1:0]   alloc_oh;
    logic [SW-1:0]        alloc_idx;
    logic                 is_sc;
    logic                 open;
    logic                 sc_acc;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic [SW-1:0]        fifo_head;
    logic                 fifo_empty;
    logic                 fifo_full;

    always_comb begin
        for (int i = 0; i < N_SLOTS; i++) begin
            idle[i] = (state_q[i] == IDLE);
        end
    end

    // Acceptance is held off while in reset so all outputs read 0.
    assign is_sc = (req_cmd == M_XSC);
    assign open  = req_valid & ~fence_req & reset;

    always_comb begin
        req_ready = 1'b0;
        unique case (1'b1)
            is_sc:   req_ready = open;
            default: req_ready = open & (|idle) & ~fifo_full;
        endcase
    end

    assign sc_acc = req_ready & is_sc;

    // Lowest set bit of the idle vector.
    assign alloc_oh   = idle & (~idle + N_SLOTS'(1));
    assign slot_alloc = (req_ready & ~is_sc) ? alloc_oh : '0;

    always_comb begin
        alloc_idx = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (alloc_oh[i]) alloc_idx = SW'(i);
        end
    end

    assign slot_addr = req_addr;
    assign slot_data = req_data;
    assign slot_tag  = req_tag;
    assign slot_cmd  = req_cmd;

    always_comb begin
        for (int i = 0; i < N_SLOTS; i++) begin
            state_d[i] = state_q[i];
            unique case (state_q[i])
                IDLE: if (slot_alloc[i]) state_d[i] = BUSY;
                BUSY: if (slot_done[i])  state_d[i] = IDLE;
                default: state_d[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                state_q[i] <= IDLE;
            end
        end else begin
            for (int i = 0; i < N_SLOTS; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            nack_valid <= 1'b0;
            nack_tag   <= '0;
        end else begin
            nack_valid <= sc_acc;
            nack_tag   <= sc_acc ? req_tag : '0;
        end
    end

    assign fifo_push = |slot_alloc;

    boom_iomshr_order_fifo #(
        .DEPTH (N_SLOTS),
        .W     (SW)
    ) u_order (
        .clock    (clock),
        .reset    (reset),
        .push     (fifo_push),
        .push_idx (alloc_idx),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    // Only the oldest allocated slot may present on A.
    assign a_valid  = ~fifo_empty & slot_a_valid[fifo_head];
    assign a_source = fifo_empty ? '0 : fifo_head;
    assign fifo_pop = a_valid & a_ready;

    always_comb begin
        slot_a_ready = '0;
        if (!fifo_empty) slot_a_ready[fifo_head] = a_ready;
    end

    always_comb begin
        slot_d_valid = '0;
        d_ready      = 1'b0;
        if (32'(d_source) < N_SLOTS) begin
            slot_d_valid[d_source] = d_valid;
            d_ready                = slot_d_ready[d_source];
        end
    end

    assign fence_done = fence_req & reset & (&idle) & fifo_empty;

`ifdef IOMSHR_SCHED_ASSERT_EN
`ifndef PRINTF_COND_
`define PRINTF_COND_ 1'b1
`endif

    a_no_sc: assert property (@(posedge clock) disable iff (!reset)
        (|slot_alloc) |-> (slot_cmd != M_XSC))
    else begin
`ifndef SYNTHESIS
        if (`PRINTF_COND_) $display("IO MSHR got SC");
`endif
    end

    a_alloc_1h: assert property (@(posedge clock) disable iff (!reset)
        $onehot0(slot_alloc))
    else begin
`ifndef SYNTHESIS
        if (`PRINTF_COND_) $display("slot_alloc not onehot0");
`endif
    end

    a_push_full: assert property (@(posedge clock) disable iff (!reset)
        !(fifo_push && fifo_full))
    else begin
`ifndef SYNTHESIS
        if (`PRINTF_COND_) $display("order fifo push when full");
`endif
    end

    a_pop_empty: assert property (@(posedge clock) disable iff (!reset)
        !(fifo_pop && fifo_empty))
    else begin
`ifndef SYNTHESIS
        if (`PRINTF_COND_) $display("order fifo pop when empty");
`endif
    end

    a_d_busy: assert property (@(posedge clock) disable iff (!reset)
        d_valid |-> (32'(d_source) < N_SLOTS && !idle[d_source]))
    else begin
`ifndef SYNTHESIS
        if (`PRINTF_COND_) $display("D beat to idle slot");
`endif
    end
`endif

endmodule
